// File: rtl/waterfall_pkg.sv
// Shared geometry, state encodings and the magnitude-to-colour map
// for the waterfall pixel source.
package waterfall_pkg;

    localparam int unsigned H_BINS    = 64;
    localparam int unsigned ROWS      = 48;
    localparam int unsigned SCALE     = 5;
    localparam int unsigned H_VISIBLE = H_BINS * SCALE;
    localparam int unsigned V_VISIBLE = ROWS * SCALE;

    localparam int unsigned ADDR_W = $clog2(ROWS * H_BINS);
    localparam int unsigned BIN_W  = $clog2(H_BINS);
    localparam int unsigned ROW_W  = $clog2(ROWS);
    localparam int unsigned CNT_W  = $clog2(ROWS + 1);
    localparam int unsigned LINE_W = $clog2(V_VISIBLE + 1);
    localparam int unsigned SUB_W  = $clog2(SCALE);

    // x / SCALE as a multiply by a rounded-up reciprocal; exact over the visible width
    localparam int unsigned RECIP_SH = 10;
    localparam int unsigned RECIP    = ((1 << RECIP_SH) + SCALE - 1) / SCALE;

    typedef enum logic {
        WR_ACCEPT,
        WR_HOLD
    } wr_state_e;

    typedef enum logic [1:0] {
        PF_IDLE,
        PF_FETCH,
        PF_DRAIN
    } pf_state_e;

    function automatic logic [23:0] colour_map(input logic [7:0] m);
        logic [7:0]  ramp;
        logic [23:0] rgb;
        ramp = {m[5:0], 2'b00};
        unique case (m[7:6])
            2'd0:    rgb = {8'h00, 8'h00, ramp};
            2'd1:    rgb = {8'h00, ramp, 8'hFF};
            2'd2:    rgb = {ramp, 8'hFF, ~ramp};
            default: rgb = {8'hFF, ~ramp, 8'h00};
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/waterfall_ram.sv
// Simple dual-port history RAM with a registered read port; contents are
// not reset so the array maps onto block RAM.
module waterfall_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 3072,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem_q[rd_addr];
        end
    end

endmodule

// File: rtl/waterfall_source.sv
// Scrolling spectrum waterfall: stores incoming lines in a circular RAM
// history and renders it newest-first, one prefetched line per display row.
module waterfall_source
    import waterfall_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic [8:0]  x,
    input  logic [7:0]  y,
    input  logic        visible,
    input  logic        lower_blank,
    output logic [23:0] rgb_data
);

    localparam int unsigned PROD_W = 18;

    wr_state_e         wr_state_q, wr_state_d;
    pf_state_e         pf_state_q, pf_state_d;
    logic              alive_q;
    logic [ROW_W-1:0]  wr_row_q, wr_row_d, newest_q, newest_d;
    logic [ROW_W-1:0]  top_q, top_d, drow_q, drow_d;
    logic [BIN_W-1:0]  wr_bin_q, wr_bin_d, pf_bin_q, pf_bin_d, rd_bin_q, rd_bin_d;
    logic [CNT_W-1:0]  rows_filled_q, rows_filled_d, shown_q, shown_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic              lb_q, vis_q, rd_vld_q, rd_vld_d;
    logic [7:0]        linebuf_q [H_BINS];
    logic [7:0]        linebuf_d [H_BINS];

    logic              frame_start, vis_fall, accept, commit, pf_start;
    logic              rd_en;
    logic [ROW_W-1:0]  rd_row;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [7:0]        rd_data;
    logic [PROD_W-1:0] bin_prod;
    logic [BIN_W-1:0]  pix_bin;
    logic              unused_bits;

    assign frame_start = lower_blank & ~lb_q;
    assign vis_fall    = vis_q & ~visible;
    assign accept      = in_valid & in_ready;
    assign commit      = accept && (wr_bin_q == BIN_W'(H_BINS - 1));
    assign wr_addr     = ADDR_W'({wr_row_q, wr_bin_q});

    waterfall_ram #(
        .DATA_W (8),
        .DEPTH  (ROWS * H_BINS),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (wr_addr),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_state_q    <= WR_ACCEPT;
            pf_state_q    <= PF_IDLE;
            alive_q       <= 1'b0;
            wr_row_q      <= '0;
            wr_bin_q      <= '0;
            newest_q      <= '0;
            rows_filled_q <= '0;
            top_q         <= '0;
            shown_q       <= '0;
            line_q        <= '0;
            sub_q         <= '0;
            drow_q        <= '0;
            pf_bin_q      <= '0;
            rd_bin_q      <= '0;
            rd_vld_q      <= 1'b0;
            lb_q          <= 1'b0;
            vis_q         <= 1'b0;
            linebuf_q     <= '{default: '0};
        end else begin
            wr_state_q    <= wr_state_d;
            pf_state_q    <= pf_state_d;
            alive_q       <= 1'b1;
            wr_row_q      <= wr_row_d;
            wr_bin_q      <= wr_bin_d;
            newest_q      <= newest_d;
            rows_filled_q <= rows_filled_d;
            top_q         <= top_d;
            shown_q       <= shown_d;
            line_q        <= line_d;
            sub_q         <= sub_d;
            drow_q        <= drow_d;
            pf_bin_q      <= pf_bin_d;
            rd_bin_q      <= rd_bin_d;
            rd_vld_q      <= rd_vld_d;
            lb_q          <= lower_blank;
            vis_q         <= visible;
            linebuf_q     <= linebuf_d;
        end
    end

    // A frame start that coincides with a commit re-opens the writer immediately
    always_comb begin
        wr_state_d = wr_state_q;
        unique case (wr_state_q)
            WR_ACCEPT: if (commit && !frame_start) wr_state_d = WR_HOLD;
            WR_HOLD:   if (frame_start) wr_state_d = WR_ACCEPT;
            default:   wr_state_d = WR_ACCEPT;
        endcase
    end

    always_comb begin
        in_ready = alive_q && (wr_state_q == WR_ACCEPT);
    end

    always_comb begin
        wr_row_d      = wr_row_q;
        wr_bin_d      = wr_bin_q;
        newest_d      = newest_q;
        rows_filled_d = rows_filled_q;
        if (accept) begin
            wr_bin_d = commit ? '0 : wr_bin_q + 1'b1;
            if (commit) begin
                newest_d = wr_row_q;
                wr_row_d = (wr_row_q == ROW_W'(ROWS - 1)) ? '0 : wr_row_q + 1'b1;
                if (rows_filled_q != CNT_W'(ROWS)) begin
                    rows_filled_d = rows_filled_q + 1'b1;
                end
            end
        end
    end

    // Snapshot uses the *_d values so a same-cycle commit is already visible
    always_comb begin
        top_d    = top_q;
        shown_d  = shown_q;
        line_d   = line_q;
        sub_d    = sub_q;
        drow_d   = drow_q;
        pf_start = 1'b0;
        if (frame_start) begin
            top_d    = newest_d;
            shown_d  = rows_filled_d;
            line_d   = '0;
            sub_d    = '0;
            drow_d   = '0;
            pf_start = 1'b1;
        end else if (vis_fall && (line_q != LINE_W'(V_VISIBLE))) begin
            line_d = line_q + 1'b1;
            if (line_d != LINE_W'(V_VISIBLE)) begin
                if (sub_q == SUB_W'(SCALE - 1)) begin
                    sub_d  = '0;
                    drow_d = drow_q + 1'b1;
                end else begin
                    sub_d = sub_q + 1'b1;
                end
                pf_start = 1'b1;
            end
        end
    end

    always_comb begin
        pf_state_d = pf_state_q;
        pf_bin_d   = pf_bin_q;
        if (pf_start) begin
            pf_state_d = PF_FETCH;
            pf_bin_d   = '0;
        end else begin
            unique case (pf_state_q)
                PF_FETCH: begin
                    pf_bin_d = pf_bin_q + 1'b1;
                    if (pf_bin_q == BIN_W'(H_BINS - 1)) pf_state_d = PF_DRAIN;
                end
                PF_DRAIN: pf_state_d = PF_IDLE;
                default:  pf_state_d = PF_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_en   = (pf_state_q == PF_FETCH);
        rd_row  = (top_q >= drow_q) ? top_q - drow_q : top_q + ROW_W'(ROWS) - drow_q;
        rd_addr = ADDR_W'({rd_row, pf_bin_q});
    end

    always_comb begin
        rd_vld_d  = rd_en;
        rd_bin_d  = pf_bin_q;
        linebuf_d = linebuf_q;
        if (rd_vld_q) begin
            linebuf_d[rd_bin_q] = (CNT_W'(drow_q) >= shown_q) ? '0 : rd_data;
        end
    end

    always_comb begin
        bin_prod    = PROD_W'(x) * PROD_W'(RECIP);
        pix_bin     = bin_prod[RECIP_SH +: BIN_W];
        unused_bits = ^{bin_prod[RECIP_SH-1:0], bin_prod[PROD_W-1:RECIP_SH+BIN_W], y};
        rgb_data    = visible ? colour_map(linebuf_q[pix_bin]) : '0;
    end

endmodule
